// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Sequencing stage wrapped around the external, purely combinational 4-bit
// ripple adder (addr4). A wide operand pair is accepted over a valid/ready
// handshake. The pair is then fed to addr4 one nibble per cycle, starting with
// the least significant nibble. addr4's carry-out is registered and becomes the
// carry-in of the next nibble. When every nibble has been summed, the
// full-width sum and the final carry are presented downstream over a second
// valid/ready handshake.
//
// Timing with out_ready held high: one IDLE cycle, NIBBLES RUN cycles and one
// DONE cycle, so one operation completes every NIBBLES+2 cycles. A new pair is
// accepted only in IDLE, so operations never overlap.
//
// Parameters
//   NIBBLES   number of 4-bit digits per operand (1..16); W = 4*NIBBLES
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  upstream offers an operand pair
//   in_ready   out  1  block can accept an operand pair (IDLE only)
//   in_a       in   W  operand A
//   in_b       in   W  operand B
//   in_cin     in   1  initial carry-in
//   add_a      out  4  nibble of A presented to addr4
//   add_b      out  4  nibble of B presented to addr4
//   add_cin    out  1  carry presented to addr4
//   add_s      in   4  addr4 sum nibble
//   add_cout   in   1  addr4 carry-out
//   out_valid  out  1  result available (DONE only)
//   out_ready  in   1  downstream accepts the result
//   out_sum    out  W  {nibble N-1 .. nibble 0} of the sum
//   out_cout   out  1  final carry-out
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout
);

  localparam int W     = 4 * NIBBLES;
  // A single-nibble build still needs a 1-bit index to keep widths legal.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;

  // The result is kept in its own registers so that out_sum/out_cout hold the
  // last finished result while the next operation is being worked on.
  logic [W-1:0]     res_sum;
  logic             res_cout;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [W-1:0]     sum_merged;
  logic             last_nibble;
  logic             accept;

  assign accept      = (state == IDLE) && in_valid;
  assign last_nibble = (idx == IDX_W'(NIBBLES - 1));

  // Nibble selection and sum merge. This is written as a compare-and-select
  // loop rather than a variable part-select, so that no out-of-range slice
  // can ever be formed, even when NIBBLES is 1. sum_merged is sum_reg with
  // the current nibble replaced by addr4's result. It is only registered in
  // RUN, so an X on add_s in any other state is never captured.
  always_comb begin
    a_nib      = 4'h0;
    b_nib      = 4'h0;
    sum_merged = sum_reg;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib              = a_reg[4*i +: 4];
        b_nib              = b_reg[4*i +: 4];
        sum_merged[4*i +: 4] = add_s;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_nibble) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers. The operands are captured only at the accept edge.
  // During RUN, each edge stores one sum nibble and moves addr4's carry-out
  // into carry_reg for the next nibble. On the final nibble, the complete
  // result is copied into the output registers at the same edge that enters
  // DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            idx       <= '0;
            sum_reg   <= '0;
          end
        end
        RUN: begin
          sum_reg   <= sum_merged;
          carry_reg <= add_cout;
          if (last_nibble) begin
            res_sum  <= sum_merged;
            res_cout <= add_cout;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake and addr4 drive outputs. addr4 sees zeros outside RUN.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    if (state == RUN) begin
      add_a   = a_nib;
      add_b   = b_nib;
      add_cin = carry_reg;
    end
  end

  assign out_sum  = res_sum;
  assign out_cout = res_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Testbench for nibble_serial_adder. It builds two instances, one with
// NIBBLES=4 and one with NIBBLES=1. Each instance is paired with a behavioural
// addr4. That model drives X whenever its adder is not in RUN, so that a
// leaked X on add_s/add_cout shows up in the results. Inputs are driven 1 time
// unit after the rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // NIBBLES = 4 instance
  logic        in_valid, in_ready, in_cin;
  logic [15:0] in_a, in_b, out_sum;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic        out_valid, out_ready, out_cout;

  // NIBBLES = 1 instance
  logic        n1_in_valid, n1_in_ready, n1_in_cin;
  logic [3:0]  n1_in_a, n1_in_b, n1_out_sum;
  logic [3:0]  n1_add_a, n1_add_b, n1_add_s;
  logic        n1_add_cin, n1_add_cout;
  logic        n1_out_valid, n1_out_ready, n1_out_cout;

  int tests_run    = 0;
  int tests_failed = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut_n1 (
    .clk(clk), .rst(rst),
    .in_valid(n1_in_valid), .in_ready(n1_in_ready),
    .in_a(n1_in_a), .in_b(n1_in_b), .in_cin(n1_in_cin),
    .add_a(n1_add_a), .add_b(n1_add_b), .add_cin(n1_add_cin),
    .add_s(n1_add_s), .add_cout(n1_add_cout),
    .out_valid(n1_out_valid), .out_ready(n1_out_ready),
    .out_sum(n1_out_sum), .out_cout(n1_out_cout)
  );

  // Behavioural addr4 models. RUN is the only state with both ready and valid low.
  logic [4:0] m4_sum, m1_sum;
  logic       run4, run1;
  assign m4_sum = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign m1_sum = {1'b0, n1_add_a} + {1'b0, n1_add_b} + {4'b0, n1_add_cin};
  assign run4   = !in_ready && !out_valid;
  assign run1   = !n1_in_ready && !n1_out_valid;
  assign add_s       = run4 ? m4_sum[3:0] : 4'bxxxx;
  assign add_cout    = run4 ? m4_sum[4]   : 1'bx;
  assign n1_add_s    = run1 ? m1_sum[3:0] : 4'bxxxx;
  assign n1_add_cout = run1 ? m1_sum[4]   : 1'bx;

  // One operation on the 4-nibble instance. lat counts the edges after the
  // accept edge, up to and including the first edge that sees out_valid high.
  // cins records add_cin on each RUN cycle; the first RUN cycle lands in bit 0.
  // The operand inputs are scrambled right after acceptance.
  task automatic do_op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic rdy, output logic [15:0] s, output logic co,
                        output int lat, output logic [3:0] cins, output bit timed_out);
    int   guard;
    logic v;
    timed_out = 1'b0;
    guard     = 0;
    cins      = 4'h0;
    lat       = 0;
    s         = 16'h0;
    co        = 1'b0;
    v         = 1'b0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      timed_out = 1'b1;
      return;
    end
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = rdy;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    in_cin   = 1'($urandom);
    for (int k = 0; k < 40; k++) begin
      v  = out_valid;
      s  = out_sum;
      co = out_cout;
      if (!v) cins = {add_cin, cins[3:1]};
      @(posedge clk); #1;
      lat++;
      if (v) break;
    end
    if (v !== 1'b1) timed_out = 1'b1;
  endtask

  // Same procedure for the single-nibble instance.
  task automatic do_op1(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        output logic [3:0] s, output logic co, output int lat,
                        output bit timed_out);
    int   guard;
    logic v;
    timed_out = 1'b0;
    guard     = 0;
    lat       = 0;
    s         = 4'h0;
    co        = 1'b0;
    v         = 1'b0;
    while (n1_in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      timed_out = 1'b1;
      return;
    end
    n1_in_a = a; n1_in_b = b; n1_in_cin = cin; n1_in_valid = 1'b1; n1_out_ready = 1'b1;
    @(posedge clk); #1;
    n1_in_valid = 1'b0;
    n1_in_a     = 4'($urandom);
    n1_in_b     = 4'($urandom);
    n1_in_cin   = 1'($urandom);
    for (int k = 0; k < 40; k++) begin
      v  = n1_out_valid;
      s  = n1_out_sum;
      co = n1_out_cout;
      @(posedge clk); #1;
      lat++;
      if (v) break;
    end
    if (v !== 1'b1) timed_out = 1'b1;
  endtask

  // Reset with in_valid also high: reset wins and nothing is accepted.
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; n1_in_valid = 1'b1;
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; n1_in_valid = 1'b0;
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL reset_handshake: got ready/valid=%b%b, want 10", in_ready, out_valid);
    end
    tests_run++;
    if ({out_sum, out_cout} !== 17'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_result: got sum=%h cout=%b, want 0000/0", out_sum, out_cout);
    end
    tests_run++;
    if ({add_a, add_b, add_cin} !== 9'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_addr4: got a=%h b=%h cin=%b, want 0/0/0", add_a, add_b, add_cin);
    end
    tests_run++;
    if ({n1_in_ready, n1_out_valid, n1_out_sum, n1_out_cout} !== 7'b10_0000_0) begin
      tests_failed++;
      $display("[TB] FAIL reset_n1: got ready=%b valid=%b sum=%h cout=%b, want 1/0/0/0",
               n1_in_ready, n1_out_valid, n1_out_sum, n1_out_cout);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_accept: got in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] s; logic co; int lat; logic [3:0] cins; bit to;
    do_op4(16'h0000, 16'h0001, 1'b0, 1'b1, s, co, lat, cins, to);
    tests_run++;
    if (to || {co, s} !== 17'h00001) begin
      tests_failed++;
      $display("[TB] FAIL basic_sum: got %b/%h timeout=%0d, want 0/0001", co, s, to);
    end
    // out_valid is first seen high by the 5th edge after acceptance.
    tests_run++;
    if (lat !== 5) begin
      tests_failed++;
      $display("[TB] FAIL basic_latency: got %0d edges, want 5", lat);
    end
    do_op4(16'h8421, 16'h1248, 1'b1, 1'b1, s, co, lat, cins, to);
    tests_run++;
    if (to || {co, s} !== 17'h0966A) begin
      tests_failed++;
      $display("[TB] FAIL basic_cin: got %b/%h, want 0/966a", co, s);
    end
  endtask

  task automatic test_carry_chain();
    logic [15:0] s; logic co; int lat; logic [3:0] cins; bit to;
    do_op4(16'h0FFF, 16'h0001, 1'b0, 1'b1, s, co, lat, cins, to);
    tests_run++;
    if (to || {co, s} !== 17'h01000) begin
      tests_failed++;
      $display("[TB] FAIL chain_sum: got %b/%h, want 0/1000", co, s);
    end
    // add_cin sequence 0,1,1,1 on the four RUN cycles (cycle 0 is in bit 0).
    tests_run++;
    if (cins !== 4'b1110) begin
      tests_failed++;
      $display("[TB] FAIL chain_add_cin: got %b, want 1110", cins);
    end
  endtask

  task automatic test_all_ones();
    logic [15:0] s; logic co; int lat; logic [3:0] cins; bit to;
    do_op4(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, s, co, lat, cins, to);
    tests_run++;
    if (to || {co, s} !== 17'h1FFFF) begin
      tests_failed++;
      $display("[TB] FAIL ones_cin1: got %b/%h, want 1/ffff", co, s);
    end
    do_op4(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, s, co, lat, cins, to);
    tests_run++;
    if (to || {co, s} !== 17'h1FFFE) begin
      tests_failed++;
      $display("[TB] FAIL ones_cin0: got %b/%h, want 1/fffe", co, s);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] s; logic co; int lat; logic [3:0] cins; bit to;
    do_op4(16'hABCD, 16'h1111, 1'b0, 1'b0, s, co, lat, cins, to);
    tests_run++;
    if (to || {co, s} !== 17'h0BCDE) begin
      tests_failed++;
      $display("[TB] FAIL bp_sum: got %b/%h, want 0/bcde", co, s);
    end
    for (int c = 0; c < 7; c++) begin
      in_valid = (c == 3);
      in_a = 16'h0101; in_b = 16'h0202; in_cin = 1'b1;
      tests_run++;
      if ({out_valid, in_ready, out_cout, out_sum} !== {1'b1, 1'b0, 1'b0, 16'hBCDE}) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold_%0d: got valid=%b ready=%b sum=%h, want 1/0/bcde",
                 c, out_valid, in_ready, out_sum);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, in_ready, out_sum} !== {1'b0, 1'b1, 16'hBCDE}) begin
      tests_failed++;
      $display("[TB] FAIL bp_release: got valid=%b ready=%b sum=%h, want 0/1/bcde",
               out_valid, in_ready, out_sum);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_pulse_ignored: got in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] s; logic co; int lat; logic [3:0] cins; bit seen;
    bit to;
    in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, add_a, add_b, add_cin} !== {1'b1, 1'b0, 9'h0}) begin
      tests_failed++;
      $display("[TB] FAIL midrst_state: got ready=%b valid=%b a=%h b=%h cin=%b, want 1/0/0/0/0",
               in_ready, out_valid, add_a, add_b, add_cin);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("[TB] FAIL midrst_no_result: got out_valid pulse, want none");
    end
    do_op4(16'h1234, 16'h4321, 1'b0, 1'b1, s, co, lat, cins, to);
    tests_run++;
    if (to || {co, s} !== 17'h05555) begin
      tests_failed++;
      $display("[TB] FAIL midrst_rerun: got %b/%h, want 0/5555", co, s);
    end
  endtask

  task automatic test_nibbles1();
    logic [3:0] s; logic co; int lat; bit to;
    do_op1(4'hF, 4'hF, 1'b1, s, co, lat, to);
    tests_run++;
    if (to || {co, s} !== 5'h1F) begin
      tests_failed++;
      $display("[TB] FAIL n1_sum: got %b/%h, want 1/f", co, s);
    end
    tests_run++;
    if (lat !== 2) begin
      tests_failed++;
      $display("[TB] FAIL n1_latency: got %0d edges, want 2", lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, s; logic c, co; int lat; logic [3:0] cins; bit to;
    logic [3:0] a1, b1, s1; logic [16:0] gold; logic [4:0] gold1;
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      gold = {1'b0, a} + {1'b0, b} + {16'h0, c};
      do_op4(a, b, c, 1'b1, s, co, lat, cins, to);
      tests_run++;
      if (to || {co, s} !== gold) begin
        tests_failed++;
        $display("[TB] FAIL rand4_%0d: %h+%h+%b got %b/%h, want %h", i, a, b, c, co, s, gold);
      end
    end
    for (int i = 0; i < 400; i++) begin
      a1 = 4'($urandom); b1 = 4'($urandom); c = 1'($urandom);
      gold1 = {1'b0, a1} + {1'b0, b1} + {4'h0, c};
      do_op1(a1, b1, c, s1, co, lat, to);
      tests_run++;
      if (to || {co, s1} !== gold1) begin
        tests_failed++;
        $display("[TB] FAIL rand1_%0d: %h+%h+%b got %b/%h, want %h", i, a1, b1, c, co, s1, gold1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_cin = 1'b0; out_ready = 1'b1;
    n1_in_valid = 1'b0; n1_in_a = 4'h0; n1_in_b = 4'h0; n1_in_cin = 1'b0; n1_out_ready = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_carry_chain();
    test_all_ones();
    test_backpressure();
    test_reset_mid_run();
    test_nibbles1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
